data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressed data memory for the CPU datapath; next generation of the single-cycle word memory.
- Adds a valid/ready request/response handshake, sized loads and stores (byte/half/word/double), sign/zero extension, misalignment and range error reporting, and a registered one-cycle read.
- Sits between the execute/memory stage and the register write-back mux.

---
 rtl/dmem_pkg.sv | 87 ++++++++
 rtl/data_memory_ctrl_if.sv | 32 +++
 rtl/dmem_array.sv | 35 +++
 rtl/data_memory_ctrl.sv | 116 +++++++++++
 tb/tb_data_memory_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types, size encodings and lane helpers for the data memory controller.
// Latency: none (pure functions and constants).
// Backpressure: not applicable.
// Contents: SZ_* funct3 size codes, FSM state type, registered response metadata,
//           strobe/misaligned/illegal_size/extend helpers on a 64-bit word.
package dmem_pkg;

  localparam int WORD_W = 64;
  localparam int LANES  = WORD_W / 8;

  // RISC-V funct3 load/store size codes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  // What the response stage needs to remember about the accepted request
  typedef struct packed {
    logic       load;
    logic       error;
    logic [2:0] size;
    logic [2:0] offset;
  } rsp_meta_t;

  // Byte-lane mask for an access of the given size starting at offset.
  // Only size[1:0] matters: the unsigned codes share widths with the signed ones.
  function automatic logic [LANES-1:0] strobe(input logic [2:0] size,
                                              input logic [2:0] offset);
    logic [LANES-1:0] base;
    base = '0;
    case (size[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  // Natural alignment: H on 2 bytes, W on 4, D on 8
  function automatic logic misaligned(input logic [2:0] size,
                                      input logic [2:0] offset);
    logic bad;
    case (size[1:0])
      2'b01:   bad = offset[0];
      2'b10:   bad = |offset[1:0];
      2'b11:   bad = |offset;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Stores have no unsigned variants; loads only reject 3'b111
  function automatic logic illegal_size(input logic       write,
                                        input logic [2:0] size);
    return write ? size[2] : (size == 3'b111);
  endfunction

  // Right-align the addressed bytes of raw, then sign/zero extend
  function automatic logic [WORD_W-1:0] extend(input logic [WORD_W-1:0] raw,
                                               input logic [2:0]        size,
                                               input logic [2:0]        offset);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] res;
    sh = raw >> {offset, 3'b000};
    case (size)
      SZ_B:    res = {{56{sh[7]}},  sh[7:0]};
      SZ_H:    res = {{48{sh[15]}}, sh[15:0]};
      SZ_W:    res = {{32{sh[31]}}, sh[31:0]};
      SZ_D:    res = raw;
      SZ_BU:   res = {56'b0, sh[7:0]};
      SZ_HU:   res = {48'b0, sh[15:0]};
      SZ_WU:   res = {32'b0, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the memory stage and the data memory.
// Latency: none (wires only).
// Backpressure: request side valid/ready, response side valid/ready.
// Signals: req_valid/req_ready/req_write/req_size/req_addr/req_wdata,
//          resp_valid/resp_ready/resp_rdata/resp_error.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  // Requester side (pipeline memory stage)
  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  // Memory side
  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// Latency: write lands at the edge; read data appears one cycle after re.
// Backpressure: none; rdata holds until the next re.
// Ports: clock, we/be/idx/wdata (write), re/idx (read), rdata.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents and read register are deliberately not reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized loads/stores, extension and error reporting.
// Latency: response one cycle after request transfer; one transaction per cycle sustained.
// Backpressure: req_ready = !resp_valid || resp_ready; response held until accepted.
// Ports: clock, reset (sync, active-high), bus (data_memory_ctrl_if.slave).
module data_memory_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  import dmem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  state_t              state_q;
  state_t              state_d;
  logic                resp_valid;
  logic                req_ready;
  logic                xfer;

  logic [IDX_W-1:0]    idx;
  logic [2:0]          offset;
  logic                range_err;
  logic                req_err;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   wdata_sh;
  logic                arr_we;
  logic                arr_re;
  logic [DATA_W-1:0]   arr_rdata;
  rsp_meta_t           meta_q;

  // Address decode
  assign idx       = bus.req_addr[IDX_W+2:3];
  assign offset    = bus.req_addr[2:0];
  assign range_err = |bus.req_addr[ADDR_W-1:IDX_W+3];
  assign req_err   = range_err
                   | misaligned(bus.req_size, offset)
                   | illegal_size(bus.req_write, bus.req_size);

  assign wstrb    = strobe(bus.req_size, offset);
  assign wdata_sh = bus.req_wdata << {offset, 3'b000};

  // A request arriving together with reset must not touch the array
  assign arr_we = xfer && !reset && bus.req_write && !req_err;
  assign arr_re = xfer && !reset && !bus.req_write;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx),
    .be    (wstrb),
    .wdata (wdata_sh),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    req_ready  = 1'b1;
    xfer       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        xfer = bus.req_valid;
        if (xfer) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        req_ready  = bus.resp_ready;
        xfer       = bus.req_valid && bus.resp_ready;
        // Retiring a response while a new one is accepted keeps us in RESP
        if (bus.resp_ready) begin
          state_d = xfer ? ST_RESP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the request's shape is registered; load data comes from the array register
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
    end else if (xfer) begin
      meta_q <= '{load:   !bus.req_write,
                  error:  req_err,
                  size:   bus.req_size,
                  offset: offset};
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_error = resp_valid && meta_q.error;
  assign bus.resp_rdata = (resp_valid && meta_q.load && !meta_q.error)
                        ? extend(arr_rdata, meta_q.size, meta_q.offset)
                        : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  data_memory_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  data_memory_ctrl #(.DATA_W(64), .DEPTH(128), .ADDR_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic wr, input logic [2:0] size, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic exp_err, input logic [63:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [2:0] size, input logic [63:0] addr,
                       input logic [63:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [63:0] b2b_addr [4];
    logic [63:0] b2b_data [4];
    logic        b2b_wr   [4];
    logic [63:0] b2b_exp  [4];

    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = SZ_D;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Directed vectors, applied one at a time; order matters (stateful memory)
    add(1, SZ_D,   64'h10,  64'h8877665544332211, 0, 64'h0);
    add(0, SZ_D,   64'h10,  64'h0, 0, 64'h8877665544332211);
    add(1, SZ_B,   64'h13,  64'h11223344556677F0, 0, 64'h0);
    add(0, SZ_B,   64'h13,  64'h0, 0, 64'hFFFFFFFFFFFFFFF0);
    add(0, SZ_BU,  64'h13,  64'h0, 0, 64'h00000000000000F0);
    add(0, SZ_W,   64'h10,  64'h0, 0, 64'hFFFFFFFFF0332211);
    add(0, SZ_H,   64'h11,  64'h0, 1, 64'h0);
    add(1, SZ_W,   64'h12,  64'hDEADBEEF, 1, 64'h0);
    add(0, SZ_D,   64'h10,  64'h0, 0, 64'h88776655F0332211);
    add(0, SZ_D,   64'h400, 64'h0, 1, 64'h0);
    add(0, SZ_HU,  64'h16,  64'h0, 0, 64'h0000000000008877);
    add(0, SZ_H,   64'h16,  64'h0, 0, 64'hFFFFFFFFFFFF8877);
    add(0, SZ_WU,  64'h14,  64'h0, 0, 64'h0000000088776655);
    add(1, SZ_H,   64'h16,  64'h1234, 0, 64'h0);
    add(0, SZ_D,   64'h10,  64'h0, 0, 64'h12346655F0332211);
    add(0, 3'b111, 64'h10,  64'h0, 1, 64'h0);
    add(1, SZ_BU,  64'h10,  64'hAA, 1, 64'h0);
    add(1, SZ_D,   64'h14,  64'h5, 1, 64'h0);
    add(0, SZ_D,   64'h10,  64'h0, 0, 64'h12346655F0332211);
    add(0, SZ_B,   64'h17,  64'h0, 0, 64'h0000000000000012);
    add(1, SZ_D,   64'h3F8, 64'h0123456789ABCDEF, 0, 64'h0);
    add(0, SZ_D,   64'h3F8, 64'h0, 0, 64'h0123456789ABCDEF);
    add(0, SZ_W,   64'h3FC, 64'h0, 0, 64'h0000000001234567);

    step();
    step();
    chk("reset resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    chk("reset resp_error", {63'b0, bus.resp_error}, 64'd0);
    chk("reset resp_rdata", bus.resp_rdata, 64'd0);
    chk("reset req_ready",  {63'b0, bus.req_ready},  64'd1);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].wr, vq[i].size, vq[i].addr, vq[i].wdata);
      step();
      chk($sformatf("vec%0d resp_valid", i), {63'b0, bus.resp_valid}, 64'd1);
      chk($sformatf("vec%0d resp_error", i), {63'b0, bus.resp_error}, {63'b0, vq[i].exp_err});
      chk($sformatf("vec%0d resp_rdata", i), bus.resp_rdata, vq[i].exp_rdata);
      bus.req_valid = 1'b0;
      step();
      chk($sformatf("vec%0d resp_drop", i), {63'b0, bus.resp_valid}, 64'd0);
    end

    // Backpressure: response held for 3 cycles while the next request waits
    bus.resp_ready = 1'b0;
    drive(0, SZ_D, 64'h10, 64'h0);
    step();
    drive(0, SZ_B, 64'h13, 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d resp_valid", k), {63'b0, bus.resp_valid}, 64'd1);
      chk($sformatf("bp%0d resp_rdata", k), bus.resp_rdata, 64'h12346655F0332211);
      chk($sformatf("bp%0d req_ready", k),  {63'b0, bus.req_ready},  64'd0);
      if (k < 2) step();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp release req_ready", {63'b0, bus.req_ready}, 64'd1);
    step();
    chk("bp next resp_valid", {63'b0, bus.resp_valid}, 64'd1);
    chk("bp next resp_rdata", bus.resp_rdata, 64'hFFFFFFFFFFFFFFF0);
    bus.req_valid = 1'b0;
    step();
    chk("bp idle resp_valid", {63'b0, bus.resp_valid}, 64'd0);

    // Back-to-back stream, one response per cycle, loads see the just-stored data
    b2b_wr[0] = 1; b2b_addr[0] = 64'h0; b2b_data[0] = 64'hCAFEF00D12345678; b2b_exp[0] = 64'h0;
    b2b_wr[1] = 0; b2b_addr[1] = 64'h0; b2b_data[1] = 64'h0; b2b_exp[1] = 64'hCAFEF00D12345678;
    b2b_wr[2] = 1; b2b_addr[2] = 64'h8; b2b_data[2] = 64'h0F1E2D3C4B5A6978; b2b_exp[2] = 64'h0;
    b2b_wr[3] = 0; b2b_addr[3] = 64'h8; b2b_data[3] = 64'h0; b2b_exp[3] = 64'h0F1E2D3C4B5A6978;
    drive(b2b_wr[0], SZ_D, b2b_addr[0], b2b_data[0]);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b2b%0d resp_valid", k), {63'b0, bus.resp_valid}, 64'd1);
      chk($sformatf("b2b%0d resp_error", k), {63'b0, bus.resp_error}, 64'd0);
      chk($sformatf("b2b%0d resp_rdata", k), bus.resp_rdata, b2b_exp[k]);
      if (k < 3) drive(b2b_wr[k+1], SZ_D, b2b_addr[k+1], b2b_data[k+1]);
      else bus.req_valid = 1'b0;
    end
    step();
    chk("b2b idle resp_valid", {63'b0, bus.resp_valid}, 64'd0);

    // Reset while a response is pending and a store is transferring
    bus.resp_ready = 1'b0;
    drive(0, SZ_D, 64'h0, 64'h0);
    step();
    chk("rst pre resp_valid", {63'b0, bus.resp_valid}, 64'd1);
    bus.resp_ready = 1'b1;
    drive(1, SZ_D, 64'h0, 64'h5555AAAA5555AAAA);
    reset = 1'b1;
    step();
    chk("rst resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    chk("rst resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst req_ready",  {63'b0, bus.req_ready},  64'd1);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    step();
    drive(0, SZ_D, 64'h0, 64'h0);
    step();
    chk("rst reload resp_valid", {63'b0, bus.resp_valid}, 64'd1);
    chk("rst reload resp_rdata", bus.resp_rdata, 64'hCAFEF00D12345678);
    bus.req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
